// File: rtl/synth_reg_pkg.sv
// Shared definitions for the synth control-port register receiver:
// default widths, receiver state encoding and address field layout.
package synth_reg_pkg;

  localparam int ADDR_BITS_DEF   = 4;
  localparam int DATA_BITS_DEF   = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // Address bit that selects the low (0) or high (1) byte of a pair
  localparam int BYTE_SEL_BIT = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    LO_HELD = 1'b1
  } rx_state_t;

  function automatic int num_pairs(input int addr_bits);
    return 1 << (addr_bits - 1);
  endfunction

endpackage

// File: rtl/synth_reg_receiver_if.sv
// Parallel register-write port between the synth parameter writer and
// the receiver, including the assembled register bank and status pulses.
interface synth_reg_receiver_if
  import synth_reg_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) ();

  localparam int NUM_PAIRS = num_pairs(ADDR_BITS);

  logic [DATA_BITS-1:0]             data_i;
  logic [ADDR_BITS-1:0]             addr_i;
  logic                             strobe_i;
  logic [NUM_PAIRS*2*DATA_BITS-1:0] regs_o;
  logic                             commit_o;
  logic [ADDR_BITS-2:0]             commit_idx_o;
  logic                             pending_o;
  logic                             err_o;

  modport master (
    output data_i, addr_i, strobe_i,
    input  regs_o, commit_o, commit_idx_o, pending_o, err_o
  );

  modport slave (
    input  data_i, addr_i, strobe_i,
    output regs_o, commit_o, commit_idx_o, pending_o, err_o
  );

endinterface

// File: rtl/sync_rise_det.sv
// Multi-flop synchronizer for an asynchronous level input followed by a
// history flop, producing a single-cycle pulse on each synchronized rise.
module sync_rise_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/synth_reg_receiver.sv
// Receives byte writes from the synth control port and assembles
// even/odd byte pairs into 16-bit parameter registers, committed atomically.
module synth_reg_receiver
  import synth_reg_pkg::*;
#(
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic                 clk,
  input logic                 rst,
  synth_reg_receiver_if.slave bus
);

  localparam int NUM_PAIRS = num_pairs(ADDR_BITS);
  localparam int IDX_BITS  = ADDR_BITS - 1;
  localparam int REG_BITS  = 2 * DATA_BITS;

  logic                wr;
  logic                byte_sel;
  logic [IDX_BITS-1:0] pair_idx;

  rx_state_t           state_q, state_d;
  logic [DATA_BITS-1:0] lo_hold_q, lo_hold_d;
  logic [IDX_BITS-1:0] idx_hold_q, idx_hold_d;
  logic [IDX_BITS-1:0] commit_idx_q, commit_idx_d;
  logic                commit_q, commit_d;
  logic                err_q, err_d;
  logic                bank_we;

  logic [NUM_PAIRS-1:0][REG_BITS-1:0] regs_q;

  // Address and data are only stable once the strobe has been synchronized,
  // so they are sampled directly in the write cycle without synchronizers.
  sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_det (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.strobe_i),
    .rise_o  (wr)
  );

  assign byte_sel = bus.addr_i[BYTE_SEL_BIT];
  assign pair_idx = bus.addr_i[ADDR_BITS-1:BYTE_SEL_BIT+1];

  always_comb begin
    state_d      = state_q;
    lo_hold_d    = lo_hold_q;
    idx_hold_d   = idx_hold_q;
    commit_idx_d = commit_idx_q;
    commit_d     = 1'b0;
    err_d        = 1'b0;
    bank_we      = 1'b0;
    if (wr) begin
      case (state_q)
        IDLE: begin
          if (!byte_sel) begin
            lo_hold_d  = bus.data_i;
            idx_hold_d = pair_idx;
            state_d    = LO_HELD;
          end else begin
            err_d = 1'b1;
          end
        end
        LO_HELD: begin
          if (!byte_sel) begin
            lo_hold_d  = bus.data_i;
            idx_hold_d = pair_idx;
          end else if (pair_idx == idx_hold_q) begin
            bank_we      = 1'b1;
            commit_d     = 1'b1;
            commit_idx_d = idx_hold_q;
            state_d      = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lo_hold_q    <= '0;
      idx_hold_q   <= '0;
      commit_idx_q <= '0;
      commit_q     <= 1'b0;
      err_q        <= 1'b0;
      regs_q       <= '0;
    end else begin
      state_q      <= state_d;
      lo_hold_q    <= lo_hold_d;
      idx_hold_q   <= idx_hold_d;
      commit_idx_q <= commit_idx_d;
      commit_q     <= commit_d;
      err_q        <= err_d;
      if (bank_we) begin
        regs_q[idx_hold_q] <= {bus.data_i, lo_hold_q};
      end
    end
  end

  assign bus.regs_o       = regs_q;
  assign bus.commit_o     = commit_q;
  assign bus.commit_idx_o = commit_idx_q;
  assign bus.pending_o    = (state_q == LO_HELD);
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_synth_reg_receiver.sv
// Scoreboard bench for synth_reg_receiver: directed writes push expected
// commit/error pulses, a negedge monitor pops and checks them.
module tb_synth_reg_receiver;

  typedef struct {
    bit          isErr;
    int          idx;
    logic [15:0] value;
    int          cycle;
  } expItem_t;

  logic clk;
  logic rst;
  int   cycleCount;
  int   vectors;
  int   miscompares;
  logic [15:0] expBank [8];
  expItem_t    expQ [$];

  synth_reg_receiver_if #(.ADDR_BITS(4), .DATA_BITS(8)) bus ();

  synth_reg_receiver #(.ADDR_BITS(4), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkBank(input string tag);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("%s reg%0d", tag, k), 32'(bus.regs_o[k*16 +: 16]),
                  32'(expBank[k]));
    end
  endtask

  // kind: 0 = no pulse expected, 1 = commit, 2 = error
  task automatic applyStimulus(input logic [3:0] a, input logic [7:0] d,
                               input int highCycles, input int lowCycles,
                               input int kind, input int expIdx,
                               input logic [15:0] expVal);
    expItem_t e;
    if (kind != 0) begin
      e.isErr = (kind == 2);
      e.idx   = expIdx;
      e.value = expVal;
      e.cycle = cycleCount + 3;
      expQ.push_back(e);
      if (kind == 1) expBank[expIdx] = expVal;
    end
    bus.addr_i   = a;
    bus.data_i   = d;
    bus.strobe_i = 1'b1;
    repeat (highCycles) @(negedge clk);
    bus.strobe_i = 1'b0;
    repeat (lowCycles) @(negedge clk);
  endtask

  // Monitor: every commit/error pulse must match the head of the queue
  initial begin
    expItem_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.commit_o || bus.err_o)) begin
        if (bus.commit_o && bus.err_o) begin
          checkOutput("commitAndErr", 32'({bus.commit_o, bus.err_o}), 32'h0);
        end else if (expQ.size() == 0) begin
          checkOutput("unexpectedPulse", 32'({bus.commit_o, bus.err_o}), 32'h0);
        end else begin
          e = expQ.pop_front();
          checkOutput("pulseKind", 32'({bus.commit_o, bus.err_o}),
                      e.isErr ? 32'h1 : 32'h2);
          checkOutput("pulseCycle", 32'(cycleCount), 32'(e.cycle));
          if (!e.isErr) begin
            checkOutput("commitIdx", 32'(bus.commit_idx_o), 32'(e.idx));
            checkOutput("commitValue", 32'(bus.regs_o[e.idx*16 +: 16]), 32'(e.value));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    cycleCount   = 0;
    rst          = 1'b1;
    bus.strobe_i = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    for (int k = 0; k < 8; k++) expBank[k] = 16'h0;
    repeat (3) @(negedge clk);
    checkOutput("resetPending", 32'(bus.pending_o), 32'h0);
    checkOutput("resetCommit", 32'(bus.commit_o), 32'h0);
    checkOutput("resetErr", 32'(bus.err_o), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkBank("reset");

    // Basic pair: addr2 = A5, addr3 = 5A -> reg1 = 5AA5
    applyStimulus(4'd2, 8'hA5, 1, 10, 0, 0, 16'h0);
    checkOutput("pendingAfterLo", 32'(bus.pending_o), 32'h1);
    applyStimulus(4'd3, 8'h5A, 1, 10, 1, 1, 16'h5AA5);
    checkOutput("pendingAfterHi", 32'(bus.pending_o), 32'h0);
    checkBank("pair1");

    // Odd write from IDLE
    applyStimulus(4'd7, 8'hEE, 1, 10, 2, 0, 16'h0);
    checkOutput("pendingOddIdle", 32'(bus.pending_o), 32'h0);
    checkBank("oddIdle");

    // Mismatched high byte discards the held low byte
    applyStimulus(4'd4, 8'h11, 1, 10, 0, 0, 16'h0);
    applyStimulus(4'd7, 8'h22, 1, 10, 2, 0, 16'h0);
    checkOutput("pendingMismatch", 32'(bus.pending_o), 32'h0);
    checkBank("mismatch");

    // Second even write replaces the held low byte
    applyStimulus(4'd4, 8'h11, 1, 10, 0, 0, 16'h0);
    applyStimulus(4'd6, 8'h33, 1, 10, 0, 0, 16'h0);
    applyStimulus(4'd7, 8'h44, 1, 10, 1, 3, 16'h4433);
    checkBank("reLo");

    // Long strobe yields a single capture; the pair then commits normally
    applyStimulus(4'd8, 8'h77, 40, 10, 0, 0, 16'h0);
    checkOutput("pendingLongStrobe", 32'(bus.pending_o), 32'h1);
    applyStimulus(4'd9, 8'h88, 1, 10, 1, 4, 16'h8877);
    checkBank("longStrobe");

    // Reset mid-pair clears everything and discards the held byte
    applyStimulus(4'd10, 8'h99, 1, 10, 0, 0, 16'h0);
    checkOutput("pendingPreReset", 32'(bus.pending_o), 32'h1);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) expBank[k] = 16'h0;
    checkOutput("midResetPending", 32'(bus.pending_o), 32'h0);
    checkOutput("midResetCommit", 32'(bus.commit_o), 32'h0);
    checkOutput("midResetErr", 32'(bus.err_o), 32'h0);
    checkBank("midReset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(4'd11, 8'hAB, 1, 10, 2, 0, 16'h0);
    checkBank("postReset");

    // Sweep every pair with writer-style spacing
    for (int k = 0; k < 8; k++) begin
      logic [7:0] lo;
      logic [7:0] hi;
      lo = 8'(16 * k + 1);
      hi = 8'(8'hC0 + k);
      applyStimulus(4'(2 * k), lo, 1, 10, 0, 0, 16'h0);
      applyStimulus(4'(2 * k + 1), hi, 1, 10, 1, k, {hi, lo});
    end
    checkBank("sweep");

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("queueDrained", 32'(expQ.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
